// File: rtl/nebula_vc_credit_ctrl_if.sv
// rtl/nebula_vc_credit_ctrl_if.sv - send/return handshake and credit status bundle for the VC credit controller
interface nebula_vc_credit_ctrl_if #(
  parameter int NUM_VCS      = 4,
  parameter int MAX_CREDITS  = 8,
  parameter int CREDIT_WIDTH = $clog2(MAX_CREDITS + 1),
  parameter int RET_WIDTH    = $clog2(MAX_CREDITS + 1),
  parameter int VC_W         = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
);
  logic                              send_valid;
  logic [VC_W-1:0]                   send_vc;
  logic                              send_accept;
  logic                              ret_valid;
  logic [VC_W-1:0]                   ret_vc;
  logic [RET_WIDTH-1:0]              ret_cnt;
  logic                              reinit;
  logic [NUM_VCS*CREDIT_WIDTH-1:0]   credit_count;
  logic [NUM_VCS-1:0]                credits_avail;
  logic [NUM_VCS-1:0]                credit_low;
  logic [NUM_VCS-1:0]                ovf_err;
  logic [NUM_VCS-1:0]                udf_err;

  modport master (
    output send_valid, send_vc, ret_valid, ret_vc, ret_cnt, reinit,
    input  send_accept, credit_count, credits_avail, credit_low, ovf_err, udf_err
  );

  modport slave (
    input  send_valid, send_vc, ret_valid, ret_vc, ret_cnt, reinit,
    output send_accept, credit_count, credits_avail, credit_low, ovf_err, udf_err
  );
endinterface

// File: rtl/nebula_vc_credit_ctrl.sv
// rtl/nebula_vc_credit_ctrl.sv - per-VC credit counters gating flit sends, with batched returns and sticky errors
module nebula_vc_credit_ctrl #(
  parameter int NUM_VCS      = 4,
  parameter int MAX_CREDITS  = 8,
  parameter int CREDIT_WIDTH = $clog2(MAX_CREDITS + 1),
  parameter int RET_WIDTH    = $clog2(MAX_CREDITS + 1),
  parameter int LOW_WM       = 2,
  parameter int VC_W         = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  nebula_vc_credit_ctrl_if.slave bus
);
  localparam logic [CREDIT_WIDTH-1:0] MAX_CNT  = CREDIT_WIDTH'(MAX_CREDITS);
  localparam logic [CREDIT_WIDTH:0]   MAX_WIDE = (CREDIT_WIDTH + 1)'(MAX_CREDITS);

  logic [CREDIT_WIDTH-1:0]         count [NUM_VCS];
  logic [CREDIT_WIDTH:0]           nxt   [NUM_VCS];
  logic [NUM_VCS-1:0]              send_hit, ret_hit, ovf_set, udf_set;
  logic [NUM_VCS-1:0]              avail, low, ovf_q, udf_q;
  logic [NUM_VCS*CREDIT_WIDTH-1:0] packed_cnt;
  logic                            accept;

  // Out-of-range VC indices match no channel, so they are ignored naturally.
  always_comb begin
    for (int v = 0; v < NUM_VCS; v++) begin
      send_hit[v] = bus.send_valid && (bus.send_vc == VC_W'(v));
      ret_hit[v]  = bus.ret_valid && (bus.ret_vc == VC_W'(v));
    end
  end

  assign accept          = !bus.reinit && |(send_hit & avail);
  assign bus.send_accept = accept;

  always_comb begin
    for (int v = 0; v < NUM_VCS; v++) begin
      nxt[v] = {1'b0, count[v]}
             + (ret_hit[v] ? (CREDIT_WIDTH + 1)'(bus.ret_cnt) : '0)
             - (CREDIT_WIDTH + 1)'(accept && send_hit[v]);
      ovf_set[v] = nxt[v] > MAX_WIDE;
      udf_set[v] = send_hit[v] && (count[v] == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < NUM_VCS; v++) count[v] <= MAX_CNT;
      ovf_q <= '0;
      udf_q <= '0;
    end else if (bus.reinit) begin
      for (int v = 0; v < NUM_VCS; v++) count[v] <= MAX_CNT;
      ovf_q <= '0;
      udf_q <= '0;
    end else begin
      for (int v = 0; v < NUM_VCS; v++)
        count[v] <= ovf_set[v] ? MAX_CNT : nxt[v][CREDIT_WIDTH-1:0];
      ovf_q <= ovf_q | ovf_set;
      udf_q <= udf_q | udf_set;
    end
  end

  always_comb begin
    packed_cnt = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      packed_cnt[v*CREDIT_WIDTH +: CREDIT_WIDTH] = count[v];
      avail[v] = (count[v] != '0);
      low[v]   = int'(count[v]) <= LOW_WM;
    end
  end

  assign bus.credit_count  = packed_cnt;
  assign bus.credits_avail = avail;
  assign bus.credit_low    = low;
  assign bus.ovf_err       = ovf_q;
  assign bus.udf_err       = udf_q;
endmodule

// File: tb/tb_nebula_vc_credit_ctrl.sv
// tb/tb_nebula_vc_credit_ctrl.sv - scoreboard bench for the VC credit controller
module tb_nebula_vc_credit_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;

  nebula_vc_credit_ctrl_if bus ();

  nebula_vc_credit_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cnt;
    logic [3:0]  avail;
    logic [3:0]  low;
    logic [3:0]  ovf;
    logic [3:0]  udf;
  } exp_t;

  exp_t     sb[$];
  int       m_cnt[4];
  bit [3:0] m_ovf, m_udf;
  int       n_checks = 0;
  int       n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int v = 0; v < 4; v++) m_cnt[v] = 8;
    m_ovf = '0;
    m_udf = '0;
  endfunction

  function automatic exp_t snapshot();
    exp_t e;
    e.cnt = '0; e.avail = '0; e.low = '0;
    for (int v = 0; v < 4; v++) begin
      e.cnt[v*4 +: 4] = 4'(m_cnt[v]);
      e.avail[v]      = (m_cnt[v] != 0);
      e.low[v]        = (m_cnt[v] <= 2);
    end
    e.ovf = m_ovf;
    e.udf = m_udf;
    return e;
  endfunction

  task automatic drive_idle();
    bus.send_valid = 1'b0; bus.send_vc = '0;
    bus.ret_valid  = 1'b0; bus.ret_vc  = '0; bus.ret_cnt = '0;
    bus.reinit     = 1'b0;
  endtask

  task automatic step(input bit sv, input int svc, input bit rv, input int rvc,
                      input int rc, input bit ri);
    bit   acc;
    int   n;
    int   nc[4];
    exp_t e;
    @(negedge clk);
    bus.send_valid = sv; bus.send_vc = 2'(svc);
    bus.ret_valid  = rv; bus.ret_vc  = 2'(rvc); bus.ret_cnt = 4'(rc);
    bus.reinit     = ri;
    #1;
    acc = sv && !ri && (m_cnt[svc] > 0);
    check_eq("send_accept", 32'(bus.send_accept), 32'(acc));
    if (ri) begin
      model_reset();
    end else begin
      for (int v = 0; v < 4; v++) begin
        n = m_cnt[v];
        if (acc && svc == v) n = n - 1;
        if (rv && rvc == v) n = n + rc;
        if (n > 8) begin n = 8; m_ovf[v] = 1'b1; end
        if (sv && svc == v && m_cnt[v] == 0) m_udf[v] = 1'b1;
        nc[v] = n;
      end
      for (int v = 0; v < 4; v++) m_cnt[v] = nc[v];
    end
    sb.push_back(snapshot());
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_eq("credit_count",  32'(bus.credit_count),  32'(e.cnt));
      check_eq("credits_avail", 32'(bus.credits_avail), 32'(e.avail));
      check_eq("credit_low",    32'(bus.credit_low),    32'(e.low));
      check_eq("ovf_err",       32'(bus.ovf_err),       32'(e.ovf));
      check_eq("udf_err",       32'(bus.udf_err),       32'(e.udf));
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_count"}, 32'(bus.credit_count),  32'h8888);
    check_eq({tag, "_avail"}, 32'(bus.credits_avail), 32'hf);
    check_eq({tag, "_low"},   32'(bus.credit_low),    32'h0);
    check_eq({tag, "_ovf"},   32'(bus.ovf_err),       32'h0);
    check_eq({tag, "_udf"},   32'(bus.udf_err),       32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    drive_idle();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_values("t1_reset");

    // T2: drain VC2, then one send too many
    for (int i = 0; i < 8; i++) step(1, 2, 0, 0, 0, 0);
    check_eq("t2_avail", 32'(bus.credits_avail), 32'hb);
    step(1, 2, 0, 0, 0, 0);
    check_eq("t2_udf", 32'(bus.udf_err), 32'h4);

    // T3: batched return then overflow clamp on VC1
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 4, 0);
    check_eq("t3_vc1_7", 32'(bus.credit_count[7:4]), 32'd7);
    step(0, 0, 1, 1, 3, 0);
    check_eq("t3_vc1_clamp", 32'(bus.credit_count[7:4]), 32'd8);
    check_eq("t3_ovf", 32'(bus.ovf_err), 32'h2);

    // T4: simultaneous send and return on VC0
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 1, 0);
    check_eq("t4_vc0_5", 32'(bus.credit_count[3:0]), 32'd5);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 1, 0);
    check_eq("t4_vc0_1", 32'(bus.credit_count[3:0]), 32'd1);

    // T5: independent VCs from vc0=4 / vc3=8
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
    step(1, 3, 1, 0, 2, 0);
    check_eq("t5_vc3", 32'(bus.credit_count[15:12]), 32'd7);
    check_eq("t5_vc0", 32'(bus.credit_count[3:0]), 32'd6);
    step(0, 0, 1, 2, 0, 0);

    for (int i = 0; i < 250; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3),
           $urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 8),
           $urandom_range(0, 40) == 0);

    // T6: reinit alongside a send with errors set
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) step(1, 2, 0, 0, 0, 0);
    step(0, 0, 1, 1, 5, 0);
    step(1, 1, 0, 0, 0, 1);
    check_reset_values("t6_reinit");

    // Mid-operation asynchronous reset
    for (int i = 0; i < 3; i++) step(1, 3, 0, 0, 0, 0);
    step(1, 3, 1, 3, 8, 0);
    @(negedge clk);
    drive_idle();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("t6_async_rst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1, 1, 1, 2, 1, 0);
    step(1, 1, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
